// File: rtl/prog_mode_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// prog_mode_ctrl
// Sequences the switch between CPU run mode and UART-programming mode and
// arbitrates the instruction-ROM / data-RAM write ports between the CPU and the
// UART programmer.
//
// States:
//   RUN     : CPU out of reset and owns the RAM port combinationally.
//   LOAD    : CPU held in reset, programmer released; programmer writes are
//             registered (1-cycle latency) and steered by address bit 14.
//   RELEASE : both held in reset for RELEASE_CYCLES cycles, then RUN.
//
// Ports:
//   clock, reset          : system clock, asynchronous active-high reset
//   start_pg_i            : one-cycle request to enter programming mode
//   upg_wen_i/adr_i/dat_i : programmer write strobe, address, data
//   upg_done_i            : programmer finished (level)
//   cpu_ram_*_i           : CPU store enable, word address, data
//   upg_rst_o, cpu_rst_o  : active-high resets to programmer and CPU
//   rom_wen_o, ram_wen_o  : write enables (never both high)
//   mem_adr_o, mem_dat_o  : muxed write address / data
//   word_cnt_o            : words written in current/last load (saturating)
//   prog_mode_o           : high whenever not in RUN
//   abort_o               : sticky, last load ended by idle timeout
// -----------------------------------------------------------------------------
module prog_mode_ctrl #(
  parameter int unsigned RELEASE_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_pg_i,
  input  logic        upg_wen_i,
  input  logic [14:0] upg_adr_i,
  input  logic [31:0] upg_dat_i,
  input  logic        upg_done_i,
  input  logic        cpu_ram_wen_i,
  input  logic [13:0] cpu_ram_adr_i,
  input  logic [31:0] cpu_ram_dat_i,
  output logic        upg_rst_o,
  output logic        cpu_rst_o,
  output logic        rom_wen_o,
  output logic        ram_wen_o,
  output logic [13:0] mem_adr_o,
  output logic [31:0] mem_dat_o,
  output logic [15:0] word_cnt_o,
  output logic        prog_mode_o,
  output logic        abort_o
);

  localparam int unsigned RCW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam int unsigned ICW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [RCW-1:0] REL_LAST  = RCW'(RELEASE_CYCLES - 1);
  localparam logic [RCW-1:0] REL_ONE   = RCW'(1);
  localparam logic [RCW-1:0] REL_ZERO  = RCW'(0);
  localparam logic [ICW-1:0] IDLE_LAST = ICW'(TIMEOUT_CYCLES - 1);
  localparam logic [ICW-1:0] IDLE_ONE  = ICW'(1);
  localparam logic [ICW-1:0] IDLE_ZERO = ICW'(0);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_nstate;
  logic [RCW-1:0] r_rel_cnt;
  logic [ICW-1:0] r_idle_cnt;
  logic           r_wr_rom;
  logic           r_wr_ram;
  logic [13:0]    r_wr_adr;
  logic [31:0]    r_wr_dat;
  logic [15:0]    r_word_cnt;
  logic           r_abort;
  logic           w_enter_load;
  logic           w_timeout;
  logic           w_capture;

  // A programmer write is only accepted while loading.
  assign w_capture = (r_state == ST_LOAD) && upg_wen_i;

  // Next-state logic and transition side-effect strobes.
  always_comb begin
    w_nstate     = r_state;
    w_enter_load = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (start_pg_i) begin
          w_nstate     = ST_LOAD;
          w_enter_load = 1'b1;
        end else begin
          w_nstate = ST_RUN;
        end
      end
      ST_LOAD: begin
        // done has priority; a cycle carrying a write is never idle
        if (upg_done_i) begin
          w_nstate = ST_RELEASE;
        end else if (!upg_wen_i && (r_idle_cnt == IDLE_LAST)) begin
          w_nstate  = ST_RELEASE;
          w_timeout = 1'b1;
        end else begin
          w_nstate = ST_LOAD;
        end
      end
      ST_RELEASE: begin
        if (start_pg_i) begin
          w_nstate     = ST_LOAD;
          w_enter_load = 1'b1;
        end else if (r_rel_cnt == REL_LAST) begin
          w_nstate = ST_RUN;
        end else begin
          w_nstate = ST_RELEASE;
        end
      end
      default: begin
        w_nstate = ST_RELEASE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_RELEASE;
    end else begin
      r_state <= w_nstate;
    end
  end

  // Release hold counter: restarts from zero on every entry into RELEASE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rel_cnt <= REL_ZERO;
    end else if ((r_state == ST_RELEASE) && (w_nstate == ST_RELEASE)) begin
      r_rel_cnt <= r_rel_cnt + REL_ONE;
    end else begin
      r_rel_cnt <= REL_ZERO;
    end
  end

  // Idle counter: cycles in LOAD since the last programmer write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_idle_cnt <= IDLE_ZERO;
    end else if ((r_state == ST_LOAD) && (w_nstate == ST_LOAD)) begin
      r_idle_cnt <= upg_wen_i ? IDLE_ZERO : (r_idle_cnt + IDLE_ONE);
    end else begin
      r_idle_cnt <= IDLE_ZERO;
    end
  end

  // Registered programmer write; a write captured in the last LOAD cycle
  // naturally lands in the first RELEASE cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_rom <= 1'b0;
      r_wr_ram <= 1'b0;
      r_wr_adr <= 14'd0;
      r_wr_dat <= 32'd0;
    end else if (w_capture) begin
      r_wr_rom <= ~upg_adr_i[14];
      r_wr_ram <= upg_adr_i[14];
      r_wr_adr <= upg_adr_i[13:0];
      r_wr_dat <= upg_dat_i;
    end else begin
      r_wr_rom <= 1'b0;
      r_wr_ram <= 1'b0;
    end
  end

  // Saturating word counter; bumps on the edge that captures the write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_word_cnt <= 16'd0;
    end else if (w_enter_load) begin
      r_word_cnt <= 16'd0;
    end else if (w_capture && (r_word_cnt != 16'hFFFF)) begin
      r_word_cnt <= r_word_cnt + 16'd1;
    end else begin
      r_word_cnt <= r_word_cnt;
    end
  end

  // Sticky abort flag, cleared only when a new load starts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_abort <= 1'b0;
    end else if (w_enter_load) begin
      r_abort <= 1'b0;
    end else if (w_timeout) begin
      r_abort <= 1'b1;
    end else begin
      r_abort <= r_abort;
    end
  end

  // Write-port mux: CPU owns RAM combinationally in RUN, otherwise the
  // registered programmer write drives the port.
  always_comb begin
    rom_wen_o = r_wr_rom;
    ram_wen_o = r_wr_ram;
    mem_adr_o = r_wr_adr;
    mem_dat_o = r_wr_dat;
    if (r_state == ST_RUN) begin
      rom_wen_o = 1'b0;
      ram_wen_o = cpu_ram_wen_i;
      mem_adr_o = cpu_ram_adr_i;
      mem_dat_o = cpu_ram_dat_i;
    end else begin
      rom_wen_o = r_wr_rom;
      ram_wen_o = r_wr_ram;
    end
  end

  assign cpu_rst_o   = (r_state != ST_RUN);
  assign upg_rst_o   = (r_state != ST_LOAD);
  assign prog_mode_o = (r_state != ST_RUN);
  assign word_cnt_o  = r_word_cnt;
  assign abort_o     = r_abort;

endmodule

// File: tb/tb_prog_mode_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for prog_mode_ctrl: the driver advances a behavioural
// model each cycle and queues the expected status and writes; a monitor on the
// falling edge pops and compares.
module tb_prog_mode_ctrl;

  localparam int REL = 16;
  localparam int TMO = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start_pg_i = 1'b0;
  logic        upg_wen_i = 1'b0;
  logic [14:0] upg_adr_i = '0;
  logic [31:0] upg_dat_i = '0;
  logic        upg_done_i = 1'b0;
  logic        cpu_ram_wen_i = 1'b0;
  logic [13:0] cpu_ram_adr_i = '0;
  logic [31:0] cpu_ram_dat_i = '0;
  logic        upg_rst_o, cpu_rst_o, rom_wen_o, ram_wen_o, prog_mode_o, abort_o;
  logic [13:0] mem_adr_o;
  logic [31:0] mem_dat_o;
  logic [15:0] word_cnt_o;

  prog_mode_ctrl #(.RELEASE_CYCLES(REL), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset), .start_pg_i(start_pg_i),
    .upg_wen_i(upg_wen_i), .upg_adr_i(upg_adr_i), .upg_dat_i(upg_dat_i),
    .upg_done_i(upg_done_i), .cpu_ram_wen_i(cpu_ram_wen_i),
    .cpu_ram_adr_i(cpu_ram_adr_i), .cpu_ram_dat_i(cpu_ram_dat_i),
    .upg_rst_o(upg_rst_o), .cpu_rst_o(cpu_rst_o), .rom_wen_o(rom_wen_o),
    .ram_wen_o(ram_wen_o), .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o),
    .word_cnt_o(word_cnt_o), .prog_mode_o(prog_mode_o), .abort_o(abort_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        cpu_rst;
    logic        upg_rst;
    logic        prog;
    logic        abort;
    logic [15:0] words;
    logic        any_wen;
  } stat_t;

  typedef struct {
    logic        rom;
    logic        ram;
    logic [13:0] adr;
    logic [31:0] dat;
  } wr_t;

  stat_t stat_q[$];
  wr_t   wr_q[$];
  int    n_checks = 0;
  int    n_pass = 0;
  int    cyc = 0;

  // Reference model, described in terms of what the CPU and programmer see.
  bit          m_held;       // CPU held in reset
  bit          m_loading;    // programmer released and loading
  int          m_hold_left;  // held cycles still to go once loading is over
  int          m_idle;       // loading cycles since last write
  int          m_words;
  bit          m_aborted;
  bit          m_pend;       // a write accepted last cycle appears this cycle
  logic [14:0] m_pend_adr;
  logic [31:0] m_pend_dat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
  endtask

  task automatic model_reset();
    m_held = 1; m_loading = 0; m_hold_left = REL; m_idle = 0;
    m_words = 0; m_aborted = 0; m_pend = 0;
  endtask

  // Advance the model across one clock edge using the inputs held over it.
  task automatic model_edge();
    bit wr_now;
    wr_now = 0;
    if (reset) begin
      model_reset();
      return;
    end
    if (!m_held) begin
      if (start_pg_i) begin
        m_held = 1; m_loading = 1; m_words = 0; m_aborted = 0; m_idle = 0;
      end
    end else if (m_loading) begin
      if (upg_wen_i) begin
        wr_now = 1;
        m_pend_adr = upg_adr_i;
        m_pend_dat = upg_dat_i;
        m_words = (m_words == 65535) ? 65535 : m_words + 1;
      end
      if (upg_done_i) begin
        m_loading = 0; m_hold_left = REL;
      end else if (!upg_wen_i && m_idle == TMO - 1) begin
        m_loading = 0; m_hold_left = REL; m_aborted = 1;
      end else begin
        m_idle = upg_wen_i ? 0 : m_idle + 1;
      end
    end else begin
      if (start_pg_i) begin
        m_loading = 1; m_words = 0; m_aborted = 0; m_idle = 0;
      end else begin
        m_hold_left--;
        if (m_hold_left == 0) m_held = 0;
      end
    end
    m_pend = wr_now;
  endtask

  // One cycle of stimulus: step the model, apply inputs, queue expectations.
  task automatic drive(input bit st, input bit wen, input logic [14:0] adr,
                       input logic [31:0] dat, input bit done, input bit cw,
                       input logic [13:0] ca, input logic [31:0] cd, input bit rst);
    stat_t s;
    wr_t   w;
    @(posedge clock);
    #1;
    model_edge();
    cyc++;
    reset = rst; start_pg_i = st; upg_wen_i = wen; upg_adr_i = adr;
    upg_dat_i = dat; upg_done_i = done; cpu_ram_wen_i = cw;
    cpu_ram_adr_i = ca; cpu_ram_dat_i = cd;
    if (rst) model_reset();
    s.cpu_rst = m_held; s.upg_rst = !m_loading; s.prog = m_held;
    s.abort = m_aborted; s.words = m_words[15:0]; s.any_wen = 1'b0;
    if (!m_held) begin
      if (cw) begin
        s.any_wen = 1'b1;
        w.rom = 1'b0; w.ram = 1'b1; w.adr = ca; w.dat = cd;
        wr_q.push_back(w);
      end
    end else if (m_pend) begin
      s.any_wen = 1'b1;
      w.rom = !m_pend_adr[14]; w.ram = m_pend_adr[14];
      w.adr = m_pend_adr[13:0]; w.dat = m_pend_dat;
      wr_q.push_back(w);
    end
    stat_q.push_back(s);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, 15'd0, 32'd0, 0, 0, 14'd0, 32'd0, 0);
  endtask

  // Monitor: compare whatever the DUT presents against the queued expectations.
  always @(negedge clock) begin
    stat_t s;
    wr_t   w;
    if (stat_q.size() > 0) begin
      s = stat_q.pop_front();
      check("cpu_rst_o", cpu_rst_o, s.cpu_rst);
      check("upg_rst_o", upg_rst_o, s.upg_rst);
      check("prog_mode_o", prog_mode_o, s.prog);
      check("abort_o", abort_o, s.abort);
      check("word_cnt_o", word_cnt_o, s.words);
      check("write_active", rom_wen_o | ram_wen_o, s.any_wen);
      if (s.any_wen || rom_wen_o || ram_wen_o) begin
        if (wr_q.size() > 0) begin
          w = wr_q.pop_front();
          check("rom_wen_o", rom_wen_o, w.rom);
          check("ram_wen_o", ram_wen_o, w.ram);
          check("mem_adr_o", mem_adr_o, w.adr);
          check("mem_dat_o", mem_dat_o, w.dat);
        end else begin
          check("unexpected_write", wr_q.size(), 1);
        end
      end
    end
  end

  initial begin
    int wen_pct;
    int pcts[4];
    bit rst_r;
    pcts[0] = 0; pcts[1] = 10; pcts[2] = 50; pcts[3] = 90;
    model_reset();
    // Power-on reset, then the CPU is held for REL cycles.
    drive(0, 0, 15'd0, 32'd0, 0, 0, 14'd0, 32'd0, 1);
    drive(0, 0, 15'd0, 32'd0, 0, 0, 14'd0, 32'd0, 1);
    idle(20);
    // CPU store passes straight through in RUN.
    drive(0, 0, 15'd0, 32'd0, 0, 1, 14'h0010, 32'hDEADBEEF, 0);
    // Load a ROM and a RAM word, then finish.
    drive(1, 0, 15'd0, 32'd0, 0, 0, 14'd0, 32'd0, 0);
    drive(0, 1, 15'h0003, 32'h11111111, 0, 1, 14'h0AAA, 32'h55555555, 0);
    drive(0, 1, 15'h4005, 32'h22222222, 0, 1, 14'h0BBB, 32'h66666666, 0);
    idle(2);
    drive(0, 0, 15'd0, 32'd0, 1, 0, 14'd0, 32'd0, 0);
    idle(20);
    // Write and done together: write lands in the first RELEASE cycle.
    drive(1, 0, 15'd0, 32'd0, 0, 0, 14'd0, 32'd0, 0);
    drive(0, 1, 15'h0007, 32'hA5A5A5A5, 0, 0, 14'd0, 32'd0, 0);
    drive(0, 1, 15'h4009, 32'h5A5A5A5A, 1, 0, 14'd0, 32'd0, 0);
    idle(20);
    // Idle timeout, sticky abort into RUN, cleared by the next start.
    drive(1, 0, 15'd0, 32'd0, 0, 0, 14'd0, 32'd0, 0);
    idle(TMO + 4);
    idle(REL + 3);
    drive(1, 0, 15'd0, 32'd0, 0, 0, 14'd0, 32'd0, 0);
    drive(0, 0, 15'd0, 32'd0, 1, 0, 14'd0, 32'd0, 0);
    idle(20);
    // Reset during LOAD with a write in flight.
    drive(1, 0, 15'd0, 32'd0, 0, 0, 14'd0, 32'd0, 0);
    drive(0, 1, 15'h0001, 32'h01020304, 0, 0, 14'd0, 32'd0, 0);
    drive(0, 1, 15'h4002, 32'h0A0B0C0D, 0, 0, 14'd0, 32'd0, 0);
    drive(0, 1, 15'h0004, 32'h99999999, 0, 0, 14'd0, 32'd0, 1);
    #1;
    check("rst_rom_wen_o", rom_wen_o, 1'b0);
    check("rst_ram_wen_o", ram_wen_o, 1'b0);
    check("rst_word_cnt_o", word_cnt_o, 16'd0);
    drive(0, 1, 15'h0004, 32'h99999999, 0, 0, 14'd0, 32'd0, 1);
    idle(20);
    // Randomized traffic with bursty write density.
    wen_pct = 50;
    rst_r = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 64 == 0) wen_pct = pcts[$urandom_range(0, 3)];
      rst_r = (!rst_r) && ($urandom_range(0, 999) < 3);
      drive($urandom_range(0, 99) < 3, $urandom_range(0, 99) < wen_pct,
            15'($urandom), $urandom, $urandom_range(0, 99) < 3,
            $urandom_range(0, 1) == 1, 14'($urandom), $urandom, rst_r);
    end
    idle(3);
    @(negedge clock);
    @(negedge clock);
    check("stat_q_drained", stat_q.size(), 0);
    check("wr_q_drained", wr_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/prog_mode_ctrl.md
Name: prog_mode_ctrl

Overview:
Sequences the switch between CPU run mode and UART-programming mode, and arbitrates the instruction-ROM and data-memory write ports between the CPU and the UART programmer. In programming mode it holds the CPU in reset, releases the UART programmer, and steers programmer writes to ROM or RAM by address bit 14. When loading finishes it holds the CPU in reset for a fixed number of cycles, then releases it.

Parameters:
RELEASE_CYCLES, 16, cycles cpu_rst_o stays high after load completes (≥1)
TIMEOUT_CYCLES, 1048576, idle cycles in LOAD with no upg write before abort (≥2)

Ports:
clock  in  1  system clock, cpu_clk domain
reset  in  1  asynchronous, active-high
start_pg_i  in  1  debounced one-cycle request to enter programming mode
upg_wen_i  in  1  UART programmer write strobe, 1 cycle per word
upg_adr_i  in  15  [14]=0 instruction ROM, [14]=1 data RAM; [13:0] word address
upg_dat_i  in  32  programmer write data
upg_done_i  in  1  programmer finished, level
cpu_ram_wen_i  in  1  CPU store enable
cpu_ram_adr_i  in  14  CPU data word address
cpu_ram_dat_i  in  32  CPU store data
upg_rst_o  out  1  reset to UART programmer, active-high
cpu_rst_o  out  1  reset to CPU core, active-high
rom_wen_o  out  1  instruction ROM write enable
ram_wen_o  out  1  data RAM write enable
mem_adr_o  out  14  muxed write/access address
mem_dat_o  out  32  muxed write data
word_cnt_o  out  16  words written in the current or last load, saturating
prog_mode_o  out  1  high in any state other than RUN (drives a status LED)
abort_o  out  1  sticky flag: last load ended by timeout

Behaviour:
- States: RUN, LOAD, RELEASE. Reset enters RELEASE with its counter cleared, so the CPU is held RELEASE_CYCLES cycles after power-on.
- Reset values: upg_rst_o=1, cpu_rst_o=1, rom_wen_o=0, ram_wen_o=0, mem_adr_o=0, mem_dat_o=0, word_cnt_o=0, prog_mode_o=1, abort_o=0. All registers are cleared asynchronously.
- RUN:
  - cpu_rst_o=0, upg_rst_o=1, rom_wen_o=0.
  - CPU owns RAM, combinationally: ram_wen_o=cpu_ram_wen_i, mem_adr_o=cpu_ram_adr_i, mem_dat_o=cpu_ram_dat_i.
  - start_pg_i=1 → LOAD next cycle, clearing word_cnt_o, abort_o and the idle counter.
- LOAD:
  - cpu_rst_o=1, upg_rst_o=0. CPU inputs are ignored.
  - Programmer writes are registered, 1-cycle latency: upg_wen_i in cycle N produces a write in cycle N+1.
  - upg_adr_i[14]=0 → rom_wen_o=1. upg_adr_i[14]=1 → ram_wen_o=1. mem_adr_o=upg_adr_i[13:0], mem_dat_o=upg_dat_i.
  - Each write increments word_cnt_o, saturating at 0xFFFF.
  - The idle counter clears on each upg_wen_i and increments otherwise.
  - upg_done_i=1 → RELEASE.
  - Idle counter reaching TIMEOUT_CYCLES-1 → RELEASE with abort_o=1.
  - upg_wen_i and upg_done_i in the same cycle: the write is still issued in the next cycle, then the state is RELEASE.
  - start_pg_i in LOAD is ignored.
- RELEASE:
  - cpu_rst_o=1, upg_rst_o=1. Any pending registered write from the last LOAD cycle completes in the first RELEASE cycle; no write is issued after that.
  - A counter runs 0..RELEASE_CYCLES-1, then → RUN. cpu_rst_o falls in the first RUN cycle.
  - start_pg_i during RELEASE → LOAD. The counter is abandoned and word_cnt_o is cleared.
- prog_mode_o = (state != RUN).
- Reset asserted mid-LOAD: the in-flight write is dropped (write enables go to 0 asynchronously) and the state machine restarts in RELEASE.
- Write enables are never high in the same cycle for ROM and RAM.

Test Plan:
1. Reset deasserted, no activity → cpu_rst_o stays 1 for exactly 16 cycles, then 0. upg_rst_o=1 and prog_mode_o=0 in RUN.
2. RUN, cpu_ram_wen_i=1, adr=0x0010, dat=0xDEADBEEF → same cycle: ram_wen_o=1, mem_adr_o=0x0010, mem_dat_o=0xDEADBEEF, rom_wen_o=0.
3. start_pg_i pulse, then programmer writes adr 0x0003/dat 0x11111111 and adr 0x4005/dat 0x22222222 →
   - rom_wen_o one cycle later with mem_adr_o=0x0003;
   - ram_wen_o one cycle later with mem_adr_o=0x0005;
   - word_cnt_o=2; cpu_rst_o=1 and upg_rst_o=0 throughout.
4. In LOAD, upg_wen_i and upg_done_i in the same cycle → the write is issued in the first RELEASE cycle, word_cnt_o increments, upg_rst_o=1, and the CPU is released 16 cycles later.
5. TIMEOUT_CYCLES=8, enter LOAD, no writes → after 8 idle cycles state=RELEASE and abort_o=1. abort_o stays 1 in RUN until the next start_pg_i.
6. Reset asserted during LOAD while upg_wen_i=1 → rom_wen_o and ram_wen_o are 0 immediately, word_cnt_o=0, and the block enters RELEASE when reset drops.
